hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Hazard detection and stall sequencer that sits in the ID stage and drives the ID/EX pipeline register's stall and write-enable controls (IRWr, Stall1, Stall2).
- Also drives the PC and IF/ID write enables.
- Detects load-use and branch-compare (branch resolved in ID) data hazards against the instructions in EX and MEM.
- Holds the stall for the required number of cycles using a small FSM and countdown, and keeps a saturating stall-cycle statistic.

Parameters:
CNT_W, 32, width of the stall_cycles statistics counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a branch compared in ID
ex_regwrite  in  1  RegWrite of instruction in EX (ID/EX output)
ex_memread  in  1  MemRead of instruction in EX
ex_dst  in  5  destination register of instruction in EX
mem_regwrite  in  1  RegWrite of instruction in MEM
mem_memread  in  1  MemRead of instruction in MEM
mem_dst  in  5  destination register of instruction in MEM
ext_busy  in  1  downstream (memory) wait; freezes whole front end
pc_wr  out  1  PC write enable
ifid_wr  out  1  IF/ID write enable
irwr  out  1  ID/EX write enable (IRWr)
stall1  out  1  bubble request, load-use cause, non-branch consumer
stall2  out  1  bubble request, branch-compare cause
stall_cycles  out  CNT_W  count of bubble cycles inserted, saturating

Behaviour:
- Match rules:
  - match_ex(r) = ex_regwrite & ex_dst!=0 & ex_dst==r.
  - match_mem(r) = mem_regwrite & mem_dst!=0 & mem_dst==r.
  - A source is live only if its id_use_* bit is 1.
- Required stall count N, evaluated in RUN only; the first matching rule wins:
  - id_branch & ex_memread & match_ex(live src): N=2, cause BR.
  - id_branch & match_ex(live src): N=1, cause BR.
  - id_branch & mem_memread & match_mem(live src): N=1, cause BR.
  - !id_branch & ex_memread & match_ex(live src): N=1, cause LU.
  - Otherwise N=0.
- Register 0 never creates a hazard.
- States: RUN, HOLD. Internal registers: cnt (2 bits), cause (LU/BR).
- Transitions:
  - In RUN with N>0 and !ext_busy:
    - Assert the bubble combinationally this cycle.
    - If N==2, go to HOLD with cnt=1. If N==1, stay in RUN; detection is re-evaluated next cycle and must resolve to N=0.
  - In HOLD with !ext_busy:
    - Assert the bubble using the latched cause; detection is not re-evaluated.
    - cnt decrements; at cnt==1 return to RUN.
- Bubble cycle outputs:
  - pc_wr=0, ifid_wr=0, irwr=1.
  - stall1=1 if cause LU; stall2=1 if cause BR; never both.
- Normal cycle outputs: pc_wr=ifid_wr=irwr=1, stall1=stall2=0.
- ext_busy=1 overrides everything:
  - pc_wr=ifid_wr=irwr=0, stall1=stall2=0.
  - State, cnt, cause and stall_cycles hold.
  - No detection is taken that cycle.
- stall_cycles: +1 on every bubble cycle (stall1|stall2 asserted); saturates at all-ones.
- Reset (asynchronous):
  - State RUN, cnt=0, cause=LU, stall_cycles=0.
  - While rst=1: pc_wr=ifid_wr=irwr=0, stall1=stall2=0.
- Reset mid-HOLD aborts the stall immediately. The first cycle after rst deasserts evaluates in RUN.
- Outputs in RUN are Mealy (same-cycle on inputs). Outputs in HOLD depend on registered state only, except for ext_busy gating.

Test Plan:
- lw $5 in EX (ex_memread=1, ex_regwrite=1, ex_dst=5), ID add reads rs=5 -> one cycle stall1=1, pc_wr=ifid_wr=0, irwr=1; next cycle (EX now bubble) all enables 1; stall_cycles=1.
- lw $7 in EX, ID beq uses rt=7 -> two consecutive cycles stall2=1, stall1=0, pc_wr=0; third cycle normal; stall_cycles=2.
- ALU writes $3 in EX, ID bne reads rs=3 -> exactly 1 cycle stall2=1; same ALU writer with a non-branch consumer -> no stall.
- ex_dst=0 with ex_memread=1, ID reads $0; or id_use_rs=0 with a matching rs -> no stall, all enables 1.
- Two-cycle branch stall with ext_busy=1 during the HOLD cycle for 3 cycles -> all outputs 0 for 3 cycles, counter frozen; after release the remaining stall2 cycle completes; stall_cycles=2.
- rst pulsed during HOLD -> outputs 0 while rst=1; after release state RUN, stall_cycles=0, no residual stall when inputs are clean.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall sequencer for the ID stage.
// Detects load-use and branch-compare data hazards against the instructions
// in EX and MEM, then inserts one or two bubbles. A bubble freezes PC and
// IF/ID while IRWr loads a bubble into ID/EX, with stall1 or stall2 telling
// downstream logic why. ext_busy freezes the whole front end, including this
// controller's state. A saturating counter records how many bubbles were issued.
module hazard_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_dst,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [4:0]       mem_dst,
    input  logic             ext_busy,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             irwr,
    output logic             stall1,
    output logic             stall2,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, HOLD} state_t;
    typedef enum logic {CAUSE_LU, CAUSE_BR} cause_t;

    state_t     state;
    logic [1:0] cnt;
    cause_t     cause;

    logic [1:0] need;
    cause_t     need_cause;
    logic       ex_hit;
    logic       mem_hit;
    logic       active;
    logic       bubble;
    cause_t     bubble_cause;

    // A writer only matters if it really writes a nonzero register equal to the source.
    function automatic logic reg_match(input logic wr, input logic [4:0] dst,
                                       input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

    // Compare the live ID sources against the EX and MEM destinations.
    always_comb begin
        ex_hit  = (id_use_rs && reg_match(ex_regwrite, ex_dst, id_rs)) ||
                  (id_use_rt && reg_match(ex_regwrite, ex_dst, id_rt));
        mem_hit = (id_use_rs && reg_match(mem_regwrite, mem_dst, id_rs)) ||
                  (id_use_rt && reg_match(mem_regwrite, mem_dst, id_rt));
    end

    // Required bubble count and cause, in priority order (first match wins).
    always_comb begin
        need       = 2'd0;
        need_cause = CAUSE_LU;
        if (id_branch && ex_memread && ex_hit) begin
            need       = 2'd2;
            need_cause = CAUSE_BR;
        end else if (id_branch && ex_hit) begin
            need       = 2'd1;
            need_cause = CAUSE_BR;
        end else if (id_branch && mem_memread && mem_hit) begin
            need       = 2'd1;
            need_cause = CAUSE_BR;
        end else if (!id_branch && ex_memread && ex_hit) begin
            need       = 2'd1;
            need_cause = CAUSE_LU;
        end
    end

    // Decide whether this cycle is a bubble: HOLD replays the latched cause,
    // RUN reacts to the live detection; reset and ext_busy suppress everything.
    always_comb begin
        active       = !rst && !ext_busy;
        bubble       = 1'b0;
        bubble_cause = cause;
        if (active) begin
            if (state == HOLD) begin
                bubble       = 1'b1;
                bubble_cause = cause;
            end else if (need != 2'd0) begin
                bubble       = 1'b1;
                bubble_cause = need_cause;
            end
        end
    end

    // Drive the pipeline enables from the bubble decision.
    always_comb begin
        pc_wr   = active && !bubble;
        ifid_wr = active && !bubble;
        irwr    = active;
        stall1  = bubble && (bubble_cause == CAUSE_LU);
        stall2  = bubble && (bubble_cause == CAUSE_BR);
    end

    // Stall sequencer: a two-bubble hazard parks in HOLD for one extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
            cause <= CAUSE_LU;
        end else if (!ext_busy) begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        cause <= need_cause;
                    end
                    if (need == 2'd2) begin
                        state <= HOLD;
                        cnt   <= 2'd1;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Saturating count of issued bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (bubble && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios with fixed expectations
// plus randomized traffic checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt;
    logic             id_use_rs, id_use_rt, id_branch;
    logic             ex_regwrite, ex_memread;
    logic [4:0]       ex_dst;
    logic             mem_regwrite, mem_memread;
    logic [4:0]       mem_dst;
    logic             ext_busy;
    logic             pc_wr, ifid_wr, irwr, stall1, stall2;
    logic [CNT_W-1:0] stall_cycles;

    int checks;
    int errors;

    // Model state: remaining latched bubbles and bubble tally.
    int               m_hold_left;
    logic [CNT_W-1:0] m_stat;

    // Samples captured by step(): {pc_wr, ifid_wr, irwr, stall1, stall2}.
    logic [4:0]       obs_ctl, exp_ctl;
    logic [CNT_W-1:0] obs_stat, exp_stat;

    localparam logic [4:0] CTL_NORM = 5'b11100;
    localparam logic [4:0] CTL_LU   = 5'b00110;
    localparam logic [4:0] CTL_BR   = 5'b00101;
    localparam logic [4:0] CTL_OFF  = 5'b00000;

    hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dst(ex_dst),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_dst(mem_dst),
        .ext_busy(ext_busy),
        .pc_wr(pc_wr), .ifid_wr(ifid_wr), .irwr(irwr), .stall1(stall1), .stall2(stall2),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural rule: how many bubbles does the ID instruction need, and why.
    function automatic void required(output int n, output logic is_br);
        logic ex_any, mem_any;
        ex_any  = (id_use_rs && ex_regwrite && ex_dst != 0 && ex_dst == id_rs) ||
                  (id_use_rt && ex_regwrite && ex_dst != 0 && ex_dst == id_rt);
        mem_any = (id_use_rs && mem_regwrite && mem_dst != 0 && mem_dst == id_rs) ||
                  (id_use_rt && mem_regwrite && mem_dst != 0 && mem_dst == id_rt);
        n = 0;
        is_br = 1'b0;
        if (id_branch && ex_memread && ex_any)        begin n = 2; is_br = 1'b1; end
        else if (id_branch && ex_any)                 begin n = 1; is_br = 1'b1; end
        else if (id_branch && mem_memread && mem_any) begin n = 1; is_br = 1'b1; end
        else if (!id_branch && ex_memread && ex_any)  begin n = 1; is_br = 1'b0; end
    endfunction

    function automatic logic [4:0] model_ctl();
        int n;
        logic br;
        if (rst || ext_busy) return CTL_OFF;
        if (m_hold_left > 0) return CTL_BR;
        required(n, br);
        if (n == 0) return CTL_NORM;
        return br ? CTL_BR : CTL_LU;
    endfunction

    task automatic model_advance();
        int n;
        logic br;
        if (rst) begin
            m_hold_left = 0;
            m_stat      = '0;
        end else if (!ext_busy) begin
            if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_stat != {CNT_W{1'b1}}) m_stat++;
            end else begin
                required(n, br);
                if (n > 0) begin
                    m_hold_left = n - 1;
                    if (m_stat != {CNT_W{1'b1}}) m_stat++;
                end
            end
        end
    endtask

    // One clock: sample DUT and model at the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        obs_ctl  = {pc_wr, ifid_wr, irwr, stall1, stall2};
        obs_stat = stall_cycles;
        exp_ctl  = model_ctl();
        exp_stat = rst ? '0 : m_stat;
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
        ex_regwrite = 0; ex_memread = 0; ex_dst = 0;
        mem_regwrite = 0; mem_memread = 0; mem_dst = 0;
        ext_busy = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        checks++;
        if (obs_ctl !== CTL_OFF) begin
            errors++; $display("[TB] FAIL reset_ctl: got %b want %b", obs_ctl, CTL_OFF);
        end
        checks++;
        if (obs_stat !== '0) begin
            errors++; $display("[TB] FAIL reset_stat: got %0d want 0", obs_stat);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL reset_release: got %b want %b", obs_ctl, CTL_NORM);
        end
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] base;
        base = m_stat;
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 5;
        id_rs = 5; id_use_rs = 1; id_rt = 9; id_use_rt = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_LU) begin
            errors++; $display("[TB] FAIL lu_bubble: got %b want %b", obs_ctl, CTL_LU);
        end
        clear_inputs();
        id_rs = 5; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL lu_after: got %b want %b", obs_ctl, CTL_NORM);
        end
        checks++;
        if (obs_stat !== base + 1) begin
            errors++; $display("[TB] FAIL lu_stat: got %0d want %0d", obs_stat, base + 1);
        end
    endtask

    task automatic test_branch_load();
        logic [CNT_W-1:0] base;
        base = m_stat;
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 7;
        id_branch = 1; id_rt = 7; id_use_rt = 1; id_rs = 2; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL br2_first: got %b want %b", obs_ctl, CTL_BR);
        end
        clear_inputs();
        id_branch = 1; id_rt = 7; id_use_rt = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL br2_second: got %b want %b", obs_ctl, CTL_BR);
        end
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL br2_third: got %b want %b", obs_ctl, CTL_NORM);
        end
        checks++;
        if (obs_stat !== base + 2) begin
            errors++; $display("[TB] FAIL br2_stat: got %0d want %0d", obs_stat, base + 2);
        end
    endtask

    task automatic test_branch_alu();
        clear_inputs();
        ex_regwrite = 1; ex_dst = 3;
        id_branch = 1; id_rs = 3; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL br1_bubble: got %b want %b", obs_ctl, CTL_BR);
        end
        clear_inputs();
        id_branch = 1; id_rs = 3; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL br1_after: got %b want %b", obs_ctl, CTL_NORM);
        end
        // Same ALU writer feeding a non-branch consumer is forwarded, not stalled.
        clear_inputs();
        ex_regwrite = 1; ex_dst = 3; id_rs = 3; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL alu_nostall: got %b want %b", obs_ctl, CTL_NORM);
        end
        // Load in MEM feeding a branch needs one bubble.
        clear_inputs();
        mem_regwrite = 1; mem_memread = 1; mem_dst = 12;
        id_branch = 1; id_rt = 12; id_use_rt = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL br_mem_load: got %b want %b", obs_ctl, CTL_BR);
        end
    endtask

    task automatic test_no_hazard();
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL reg_zero: got %b want %b", obs_ctl, CTL_NORM);
        end
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 6; id_rs = 6; id_use_rs = 0;
        step();
        checks++;
        if (obs_ctl !== CTL_NORM) begin
            errors++; $display("[TB] FAIL unused_src: got %b want %b", obs_ctl, CTL_NORM);
        end
    endtask

    task automatic test_busy_hold();
        logic [CNT_W-1:0] base;
        base = m_stat;
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 7; id_branch = 1; id_rt = 7; id_use_rt = 1;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL busy_first: got %b want %b", obs_ctl, CTL_BR);
        end
        clear_inputs();
        ext_busy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_ctl !== CTL_OFF || obs_stat !== base + 1) begin
                errors++;
                $display("[TB] FAIL busy_freeze%0d: got %b/%0d want %b/%0d",
                         i, obs_ctl, obs_stat, CTL_OFF, base + 1);
            end
        end
        ext_busy = 0;
        step();
        checks++;
        if (obs_ctl !== CTL_BR) begin
            errors++; $display("[TB] FAIL busy_resume: got %b want %b", obs_ctl, CTL_BR);
        end
        step();
        checks++;
        if (obs_ctl !== CTL_NORM || obs_stat !== base + 2) begin
            errors++;
            $display("[TB] FAIL busy_done: got %b/%0d want %b/%0d",
                     obs_ctl, obs_stat, CTL_NORM, base + 2);
        end
    endtask

    task automatic test_reset_mid_hold();
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 4; id_branch = 1; id_rs = 4; id_use_rs = 1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_ctl !== CTL_OFF || obs_stat !== '0) begin
                errors++;
                $display("[TB] FAIL rst_hold%0d: got %b/%0d want %b/0", i, obs_ctl, obs_stat, CTL_OFF);
            end
        end
        rst = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (obs_ctl !== CTL_NORM || obs_stat !== '0) begin
            errors++;
            $display("[TB] FAIL rst_after: got %b/%0d want %b/0", obs_ctl, obs_stat, CTL_NORM);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            id_branch    = 1'($urandom);
            ex_regwrite  = 1'($urandom);
            ex_memread   = 1'($urandom);
            ex_dst       = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom);
            mem_memread  = 1'($urandom);
            mem_dst      = 5'($urandom_range(0, 3));
            ext_busy     = ($urandom_range(0, 9) < 2);
            rst          = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                errors++; $display("[TB] FAIL rand_ctl@%0d: got %b want %b", i, obs_ctl, exp_ctl);
            end
            checks++;
            if (obs_stat !== exp_stat) begin
                errors++; $display("[TB] FAIL rand_stat@%0d: got %0d want %0d", i, obs_stat, exp_stat);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_hold_left = 0;
        m_stat      = '0;
        rst         = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_no_hazard();
        test_busy_hold();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
